// File: rtl/conv_window_gen.sv
// Streaming WIN x WIN sliding-window generator (stride 1, no padding) for raster-ordered pixels.
// Optional macro CONV_WIN_COORD_EN adds out_row/out_col: the top-left coordinate of each window.
module conv_window_gen #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int WIN    = 3,
   parameter int DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIN*WIN*DATA_W-1:0]  out_window,
   output logic                       out_last
`ifdef CONV_WIN_COORD_EN
   ,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic [$clog2(IMG_W)-1:0]   out_col
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int WB = WIN * WIN * DATA_W;

   localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

   logic [CW-1:0]      col_p0;
   logic [RW-1:0]      row_p0;
   logic [DATA_W-1:0]  line_buf [WIN-1][IMG_W];
   logic [WB-1:0]      win_p0;
   logic [DATA_W-1:0]  col_vec [WIN];
   logic [WB-1:0]      win_nxt;
   logic               accept;
   logic               emit;

   logic               vld_p1;
   logic               last_p1;
   logic [WB-1:0]      window_p1;
`ifdef CONV_WIN_COORD_EN
   logic [RW-1:0]      row_p1;
   logic [CW-1:0]      col_p1;
`endif

   assign in_ready = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;
   assign emit     = accept && (row_p0 >= ROW_FIRST) && (col_p0 >= COL_FIRST);

   // Stage p0: raster position, line buffers and window shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_p0 <= '0;
         row_p0 <= '0;
      end else if (accept) begin
         if (col_p0 == COL_LAST) begin
            col_p0 <= '0;
            row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
         end else begin
            col_p0 <= col_p0 + 1'b1;
         end
      end
   end

   // Column entering the window: older rows from the line buffers, newest row is the live pixel.
   always_comb begin
      for (int k = 0; k < WIN - 1; k++) begin
         col_vec[k] = line_buf[k][col_p0];
      end
      col_vec[WIN-1] = in_data;
   end

   always_comb begin
      win_nxt = '0;
      for (int k = 0; k < WIN; k++) begin
         for (int l = 0; l < WIN - 1; l++) begin
            win_nxt[(k*WIN+l)*DATA_W +: DATA_W] = win_p0[(k*WIN+l+1)*DATA_W +: DATA_W];
         end
         win_nxt[(k*WIN+WIN-1)*DATA_W +: DATA_W] = col_vec[k];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < WIN - 2; i++) begin
            line_buf[i][col_p0] <= line_buf[i+1][col_p0];
         end
         line_buf[WIN-2][col_p0] <= in_data;
         win_p0 <= win_nxt;
      end
   end

   // Stage p1: output register, loaded only when a complete window is formed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
         window_p1 <= '0;
`ifdef CONV_WIN_COORD_EN
         row_p1    <= '0;
         col_p1    <= '0;
`endif
      end else if (emit) begin
         vld_p1    <= 1'b1;
         last_p1   <= (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);
         window_p1 <= win_nxt;
`ifdef CONV_WIN_COORD_EN
         row_p1    <= row_p0 - ROW_FIRST;
         col_p1    <= col_p0 - COL_FIRST;
`endif
      end else if (out_ready) begin
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
      end
   end

   assign out_valid  = vld_p1;
   assign out_last   = last_p1;
   assign out_window = window_p1;
`ifdef CONV_WIN_COORD_EN
   assign out_row    = row_p1;
   assign out_col    = col_p1;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed 4x4 tests on a small instance, randomized handshakes on a 64x64 instance.
module tb_conv_window_gen;

   localparam int SW = 4;
   localparam int SH = 4;
   localparam int WN = 3;
   localparam int DW = 16;
   localparam int BW = 64;
   localparam int BH = 64;
   localparam int NF = 3;
   localparam int WW = WN * WN * DW;
   localparam int B_WINS = (BH - WN + 1) * (BW - WN + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
   logic [DW-1:0] s_in_data;
   logic [WW-1:0] s_out_window;
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [DW-1:0] b_in_data;
   logic [WW-1:0] b_out_window;
`ifdef CONV_WIN_COORD_EN
   logic [1:0]    s_out_row, s_out_col;
   logic [5:0]    b_out_row, b_out_col;
`endif

   conv_window_gen #(.IMG_W(SW), .IMG_H(SH), .WIN(WN), .DATA_W(DW)) u_small (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_window(s_out_window), .out_last(s_out_last)
`ifdef CONV_WIN_COORD_EN
      , .out_row(s_out_row), .out_col(s_out_col)
`endif
   );

   conv_window_gen #(.IMG_W(BW), .IMG_H(BH), .WIN(WN), .DATA_W(DW)) u_big (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_window(b_out_window), .out_last(b_out_last)
`ifdef CONV_WIN_COORD_EN
      , .out_row(b_out_row), .out_col(b_out_col)
`endif
   );

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: window with top-left (top,left) of a 4x4 frame whose pixel (r,c) is base+r*4+c.
   logic [WW-1:0] s_exp_q[$];
   bit            s_last_q[$];
   int            s_row_q[$], s_col_q[$];
   int            s_pix_q[$];
   int            s_win_cnt;

   function automatic logic [WW-1:0] small_win(input int base, input int top, input int left);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < WN; k++)
         for (int l = 0; l < WN; l++)
            w[(k*WN+l)*DW +: DW] = DW'(base + (top + k) * SW + left + l);
      return w;
   endfunction

   task automatic push_small_frame(input int base);
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++)
            s_pix_q.push_back(base + r * SW + c);
      for (int t = 0; t <= SH - WN; t++)
         for (int l = 0; l <= SW - WN; l++) begin
            s_exp_q.push_back(small_win(base, t, l));
            s_last_q.push_back(t == SH - WN && l == SW - WN);
            s_row_q.push_back(t);
            s_col_q.push_back(l);
         end
   endtask

   task automatic s_step(input logic v, input logic [DW-1:0] d, input logic r,
                         output logic acc, output logic ov, output logic ir);
      @(negedge clk);
      s_in_valid = v; s_in_data = d; s_out_ready = r;
      #1;
      ov  = s_out_valid;
      ir  = s_in_ready;
      acc = v && ir;
      if (ov && r) begin
         s_win_cnt++;
         if (s_exp_q.size() == 0) begin
            chk("s_unexpected_window", WW'(s_out_valid), WW'(0));
         end else begin
            chk("s_window", s_out_window, s_exp_q.pop_front());
            chk("s_last", WW'(s_out_last), WW'(s_last_q.pop_front()));
`ifdef CONV_WIN_COORD_EN
            chk("s_out_row", WW'(s_out_row), WW'(s_row_q.pop_front()));
            chk("s_out_col", WW'(s_out_col), WW'(s_col_q.pop_front()));
`endif
         end
      end
   endtask

   // Feeds all queued pixels with in_valid held high; optional stall right after the first window.
   task automatic s_feed(input int stall_len, input int n_wins);
      int idx, guard, stall_left;
      bit prev10;
      logic acc, ov, ir, r;
      idx = 0; guard = 0; stall_left = 0; prev10 = 0; s_win_cnt = 0;
      while (idx < s_pix_q.size() && guard < 500) begin
         guard++;
         r = (stall_left == 0);
         s_step(1'b1, DW'(s_pix_q[idx]), r, acc, ov, ir);
         if (!r) begin
            chk("stall_in_ready", WW'(ir), WW'(0));
            chk("stall_out_valid", WW'(ov), WW'(1));
            chk("stall_window", s_out_window, s_exp_q[0]);
            stall_left--;
         end
         if (prev10) chk("first_window_latency", WW'(ov), WW'(1));
         prev10 = 0;
         if (acc) begin
            if (idx == 10) begin
               chk("no_early_window", WW'(ov), WW'(0));
               prev10 = 1;
               stall_left = stall_len;
            end
            idx++;
         end
      end
      chk("s_feed_done", WW'(idx), WW'(s_pix_q.size()));
      for (int i = 0; i < 20 && s_exp_q.size() != 0; i++) s_step(1'b0, '0, 1'b1, acc, ov, ir);
      s_step(1'b0, '0, 1'b1, acc, ov, ir);
      chk("s_window_count", WW'(s_win_cnt), WW'(n_wins));
      chk("s_windows_left", WW'(s_exp_q.size()), WW'(0));
      s_pix_q.delete(); s_exp_q.delete(); s_last_q.delete(); s_row_q.delete(); s_col_q.delete();
   endtask

   // Large-instance reference: random frames stored as arrays, windows enumerated per frame.
   logic [DW-1:0] bimg [NF][BH][BW];
   logic [WW-1:0] b_exp_q[$];
   bit            b_last_q[$];
   logic [DW-1:0] b_pix_q[$];
   int            b_win_cnt, b_last_cnt, b_frame_wins;

   task automatic b_step(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
      @(negedge clk);
      b_in_valid = v; b_in_data = d; b_out_ready = r;
      #1;
      acc = v && b_in_ready;
      if (b_out_valid && r) begin
         b_win_cnt++;
         b_frame_wins++;
         if (b_exp_q.size() == 0) begin
            chk("b_unexpected_window", WW'(b_out_valid), WW'(0));
         end else begin
            chk("b_window", b_out_window, b_exp_q.pop_front());
            chk("b_last", WW'(b_out_last), WW'(b_last_q.pop_front()));
         end
         if (b_out_last) begin
            b_last_cnt++;
            chk("b_frame_windows", WW'(b_frame_wins), WW'(B_WINS));
            b_frame_wins = 0;
         end
      end
   endtask

   task automatic run_big();
      int idx, guard;
      logic acc;
      logic [WW-1:0] w;
      for (int f = 0; f < NF; f++) begin
         for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++) begin
               bimg[f][r][c] = DW'($urandom);
               b_pix_q.push_back(bimg[f][r][c]);
            end
         for (int t = 0; t <= BH - WN; t++)
            for (int l = 0; l <= BW - WN; l++) begin
               for (int k = 0; k < WN; k++)
                  for (int m = 0; m < WN; m++)
                     w[(k*WN+m)*DW +: DW] = bimg[f][t+k][l+m];
               b_exp_q.push_back(w);
               b_last_q.push_back(t == BH - WN && l == BW - WN);
            end
      end
      idx = 0; guard = 0; b_win_cnt = 0; b_last_cnt = 0; b_frame_wins = 0;
      while (idx < b_pix_q.size() && guard < 80000) begin
         guard++;
         b_step(1'($urandom_range(0, 1)), b_pix_q[idx], 1'($urandom_range(0, 1)), acc);
         if (acc) idx++;
      end
      chk("b_feed_done", WW'(idx), WW'(b_pix_q.size()));
      for (int i = 0; i < 50 && b_exp_q.size() != 0; i++) b_step(1'b0, '0, 1'b1, acc);
      chk("b_window_total", WW'(b_win_cnt), WW'(NF * B_WINS));
      chk("b_last_count", WW'(b_last_cnt), WW'(NF));
      chk("b_windows_left", WW'(b_exp_q.size()), WW'(0));
   endtask

   initial begin
      logic acc, ov, ir;
      reset = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_out_valid", WW'(s_out_valid), WW'(0));
      chk("reset_out_last", WW'(s_out_last), WW'(0));
      chk("reset_out_window", s_out_window, WW'(0));
      chk("reset_big_out_valid", WW'(b_out_valid), WW'(0));
      reset = 1'b0;

      // Basic 4x4 frame
      push_small_frame(0);
      s_feed(0, 4);

      // Backpressure right after the first window
      push_small_frame(0);
      s_feed(5, 4);

      // Two frames back to back
      push_small_frame(0);
      push_small_frame(100);
      chk("second_frame_first_window_ref", s_exp_q[4], small_win(100, 0, 0));
      s_feed(0, 8);

      // Reset after 7 pixels, then a fresh frame
      for (int i = 0; i < 7; i++) s_step(1'b1, DW'(i), 1'b1, acc, ov, ir);
      @(negedge clk);
      s_in_valid = 1'b0;
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("reset_mid_out_valid", WW'(s_out_valid), WW'(0));
      end
      reset = 1'b0;
      push_small_frame(0);
      s_feed(0, 4);

      // Randomized handshakes over several default-size frames
      run_big();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
